// File: rtl/product_accumulator.sv
// product_accumulator
//   Accumulates a frame of 6-bit unsigned products from an upstream 3x3
//   multiplier stage and presents the frame sum, the beat count and a sticky
//   overflow flag through a valid/ready result port.
//
//   Parameters
//     ACC_W    accumulator / result width in bits (>= 6)
//     MAX_CNT  maximum products per frame (1..255)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   product beat valid
//     in_prod    6-bit unsigned product
//     in_last    final beat of the frame (only meaningful when accepted)
//     in_ready   block can take a product (state-decoded, registered)
//     out_valid  frame result available (registered)
//     out_ready  consumer accepts the result
//     out_sum    frame sum (ACC_W bits)
//     out_cnt    products in the frame (8 bits)
//     out_ovf    frame sum exceeded 2^ACC_W-1 at some point
//
//   Build option
//     PRODUCT_ACC_SATURATE_EN  defined: acc clamps at 2^ACC_W-1 on overflow;
//                              undefined: acc wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter int unsigned ACC_W   = 10,
    parameter int unsigned MAX_CNT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       in_prod,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_cnt,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic               accept_c;
    logic [SUM_W-1:0]   sum_ext_c;
    logic [ACC_W-1:0]   acc_next_c;
    logic [CNT_W-1:0]   cnt_next_c;
    logic               ovf_next_c;
    logic               frame_end_c;

    // Post-update accumulator values for an accepted beat
    always_comb begin
        accept_c    = 1'b0;
        sum_ext_c   = '0;
        acc_next_c  = acc;
        cnt_next_c  = cnt;
        ovf_next_c  = ovf;
        frame_end_c = 1'b0;

        accept_c  = in_valid && (state != HOLD);
        // One spare bit catches the carry out of the ACC_W-bit sum
        sum_ext_c = {1'b0, acc} + SUM_W'(in_prod);

        if (state == IDLE) begin
            acc_next_c = ACC_W'(in_prod);
            cnt_next_c = CNT_W'(1);
            ovf_next_c = 1'b0;
        end else begin
            cnt_next_c = cnt + CNT_W'(1);
            ovf_next_c = ovf | sum_ext_c[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
            // Once clamped, every later non-zero product carries again,
            // so acc stays pinned at full scale until frame end
            acc_next_c = sum_ext_c[ACC_W] ? {ACC_W{1'b1}} : sum_ext_c[ACC_W-1:0];
`else
            acc_next_c = sum_ext_c[ACC_W-1:0];
`endif
        end

        frame_end_c = in_last || (cnt_next_c == CNT_W'(MAX_CNT));
    end

    // Frame FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept_c) begin
                        acc <= acc_next_c;
                        cnt <= cnt_next_c;
                        ovf <= ovf_next_c;
                        if (frame_end_c) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next_c;
                            out_cnt   <= cnt_next_c;
                            out_ovf   <= ovf_next_c;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_cnt   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Drives identical directed frames into a 10-bit and an 8-bit accumulator.
//   A frame-level model (true integer sums) predicts handshake and result
//   outputs every cycle; literal expectations pin the model on key frames.
module tb_product_accumulator;

    localparam int MAX_CNT = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] in_prod;
    logic       in_last;
    logic       out_ready;

    logic       ir10, ov10, ovf10;
    logic [9:0] sum10;
    logic [7:0] cnt10;
    logic       ir8, ov8, ovf8;
    logic [7:0] sum8;
    logic [7:0] cnt8;

    int n_cmp = 0;
    int n_bad = 0;

    product_accumulator #(.ACC_W(10), .MAX_CNT(MAX_CNT)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod),
        .in_last(in_last), .in_ready(ir10), .out_valid(ov10),
        .out_ready(out_ready), .out_sum(sum10), .out_cnt(cnt10), .out_ovf(ovf10)
    );

    product_accumulator #(.ACC_W(8), .MAX_CNT(MAX_CNT)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod),
        .in_last(in_last), .in_ready(ir8), .out_valid(ov8),
        .out_ready(out_ready), .out_sum(sum8), .out_cnt(cnt8), .out_ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Frame-level model: a result is pending or a frame is being gathered
    bit m_hold;
    bit m_active;
    int m_sum, m_cnt;
    int r_sum, r_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 0; m_active = 0;
            m_sum = 0; m_cnt = 0; r_sum = 0; r_cnt = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            if (!m_active) begin
                m_sum = 0; m_cnt = 0; m_active = 1;
            end
            m_sum += int'(in_prod);
            m_cnt++;
            if (in_last || m_cnt == MAX_CNT) begin
                r_sum = m_sum; r_cnt = m_cnt;
                m_hold = 1; m_active = 0;
            end
        end
    end

    function automatic int exp_sum(input int s, input int w);
        int full;
        full = (1 << w) - 1;
`ifdef PRODUCT_ACC_SATURATE_EN
        return (s > full) ? full : s;
`else
        return s % (1 << w);
`endif
    endfunction

    task automatic compare_one(input string tag, input int w, input logic ir,
                               input logic ov, input int s, input int c, input logic of);
        if (!rst_n) begin
            chk({tag, "_rst_in_ready"}, 32'(ir), 1);
            chk({tag, "_rst_out_valid"}, 32'(ov), 0);
            chk({tag, "_rst_out_sum"}, 32'(s), 0);
            chk({tag, "_rst_out_cnt"}, 32'(c), 0);
            chk({tag, "_rst_out_ovf"}, 32'(of), 0);
        end else begin
            chk({tag, "_in_ready"}, 32'(ir), 32'(!m_hold));
            chk({tag, "_out_valid"}, 32'(ov), 32'(m_hold));
            if (m_hold) begin
                chk({tag, "_out_sum"}, 32'(s), 32'(exp_sum(r_sum, w)));
                chk({tag, "_out_cnt"}, 32'(c), 32'(r_cnt));
                chk({tag, "_out_ovf"}, 32'(of), 32'(r_sum > ((1 << w) - 1)));
            end
        end
    endtask

    always @(negedge clk) begin
        compare_one("w10", 10, ir10, ov10, int'(sum10), int'(cnt10), ovf10);
        compare_one("w8", 8, ir8, ov8, int'(sum8), int'(cnt8), ovf8);
    end

    task automatic cyc(input logic v, input logic [5:0] p, input logic l, input logic r);
        in_valid  = v;
        in_prod   = p;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(ir10), 1);
        chk("reset_out_valid", 32'(ov10), 0);
        chk("reset_out_sum", 32'(sum10), 0);

        // 5, 7, 9(last) with an idle gap carrying a stray in_last
        cyc(1, 6'd5, 0, 0);
        cyc(0, 6'd0, 1, 0);
        cyc(1, 6'd7, 0, 0);
        cyc(1, 6'd9, 1, 0);
        @(negedge clk);
        chk("f1_out_valid", 32'(ov10), 1);
        chk("f1_out_sum", 32'(sum10), 21);
        chk("f1_out_cnt", 32'(cnt10), 3);
        chk("f1_out_ovf", 32'(ovf10), 0);
        cyc(0, 6'd0, 0, 1);
        @(negedge clk);
        chk("f1_release_valid", 32'(ov10), 0);
        chk("f1_release_ready", 32'(ir10), 1);

        // Sixteen beats of 49 close on the count limit
        for (int i = 0; i < 16; i++) cyc(1, 6'd49, 0, 0);
        @(negedge clk);
        chk("f2_out_sum", 32'(sum10), 784);
        chk("f2_out_cnt", 32'(cnt10), 16);
        chk("f2_in_ready", 32'(ir10), 0);
        chk("f2_w8_ovf", 32'(ovf8), 1);
        cyc(0, 6'd0, 0, 1);

        // Single-beat frame held against back-pressure and ignored input beats
        cyc(1, 6'd42, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("f3_hold_valid", 32'(ov10), 1);
            chk("f3_hold_sum", 32'(sum10), 42);
            chk("f3_hold_cnt", 32'(cnt10), 1);
            chk("f3_hold_ready", 32'(ir10), 0);
            cyc(1, 6'd63, 1, 0);
        end
        cyc(0, 6'd0, 0, 1);
        @(negedge clk);
        chk("f3_idle_valid", 32'(ov10), 0);
        chk("f3_idle_ready", 32'(ir10), 1);

        // Six beats of 63: overflows the 8-bit build only
        for (int i = 0; i < 6; i++) cyc(1, 6'd63, (i == 5), 0);
        @(negedge clk);
        chk("f4_w8_ovf", 32'(ovf8), 1);
`ifdef PRODUCT_ACC_SATURATE_EN
        chk("f4_w8_sum", 32'(sum8), 255);
`else
        chk("f4_w8_sum", 32'(sum8), 122);
`endif
        chk("f4_w10_sum", 32'(sum10), 378);
        chk("f4_w10_ovf", 32'(ovf10), 0);
        cyc(0, 6'd0, 0, 1);

        // Sum lands exactly on 8-bit full scale without overflowing
        for (int i = 0; i < 4; i++) cyc(1, 6'd63, 0, 0);
        cyc(1, 6'd3, 1, 0);
        @(negedge clk);
        chk("f5_w8_sum", 32'(sum8), 255);
        chk("f5_w8_ovf", 32'(ovf8), 0);
        cyc(0, 6'd0, 0, 1);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) cyc(1, 6'd3, 0, 0);
        rst_n = 1'b0;
        cyc(0, 6'd0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 6'd10, 1, 0);
        @(negedge clk);
        chk("f6_out_valid", 32'(ov10), 1);
        chk("f6_out_sum", 32'(sum10), 10);
        chk("f6_out_cnt", 32'(cnt10), 1);
        cyc(0, 6'd0, 0, 1);

        // Reset while a result is pending
        cyc(1, 6'd20, 1, 0);
        rst_n = 1'b0;
        cyc(0, 6'd0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 6'd0, 0, 0);
        @(negedge clk);
        chk("f7_discard_valid", 32'(ov10), 0);

        repeat (3) cyc(0, 6'd0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
